// File: rtl/ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : ctrl_seq_pkg
// Desc   : Shared state, opcode and instruction-class definitions for ctrl_seq
// Rev    : 1.0  initial release
// ============================================================================
package ctrl_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_HALT  = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU    = 3'd0,
      CLS_HALT   = 3'd1,
      CLS_STORE  = 3'd2,
      CLS_LOAD   = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_CMP    = 3'd5
   } iclass_t;

   localparam logic [4:0] OP_ST     = 5'b11011;
   localparam logic [4:0] OP_LD     = 5'b11010;
   localparam logic [2:0] OP_CMP    = 3'b111;
   localparam logic [3:0] OP_BR_NIB = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/ctrl_seq_decode.sv
`default_nettype none
// ============================================================================
// Module : ctrl_seq_decode
// Desc   : Combinational IR -> instruction class map, halt has top priority
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_seq_decode
   import ctrl_seq_pkg::*;
#(
   parameter int IW = 9
) (
   input  logic [IW-1:0] ir,
   output iclass_t       cls
);

   always_comb begin
      cls = CLS_ALU;
      if (&ir)
         cls = CLS_HALT;
      else if (ir[IW-1 -: 5] == OP_ST)
         cls = CLS_STORE;
      else if (ir[IW-1 -: 5] == OP_LD)
         cls = CLS_LOAD;
      else if (ir[3:0] == OP_BR_NIB)
         cls = CLS_BRANCH;
      else if (ir[IW-1 -: 3] == OP_CMP)
         cls = CLS_CMP;
   end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module : ctrl_seq
// Desc   : Multi-cycle fetch/exec/mem/halt sequencer with internal IR.
//          Optional statistics counters enabled by CTRL_SEQ_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module ctrl_seq
   import ctrl_seq_pkg::*;
#(
   parameter int IW          = 9,
   parameter int TW          = 2,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          Start,
   input  logic [IW-1:0] Instruction,
   input  logic          InstrValid,
   input  logic          Zero,
   input  logic          MemAck,
   output logic          Fetch,
   output logic          RegWrEn,
   output logic          MemWrEn,
   output logic          MemRdEn,
   output logic          LoadInst,
   output logic          BranchTaken,
   output logic [TW-1:0] PCTarg,
   output logic          Busy,
   output logic          Ack,
   output logic          Err
`ifdef CTRL_SEQ_STATS_EN
   ,
   output logic [15:0]   InstrCount,
   output logic [15:0]   CycleCount
`endif
);

   localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(MEM_TIMEOUT - 1);
   localparam logic [CW-1:0] TMO_SAT  = CW'(MEM_TIMEOUT);

   state_t        state;
   state_t        state_nxt;
   logic [IW-1:0] ir;
   logic [CW-1:0] tmo_cnt;
   logic          err_flag;
   logic          br_taken;
   logic          tmo_last;
   iclass_t       cls;

   ctrl_seq_decode #(.IW(IW)) u_decode (
      .ir  (ir),
      .cls (cls)
   );

   assign tmo_last = (tmo_cnt == TMO_LAST);

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= ST_IDLE;
         ir       <= '0;
         tmo_cnt  <= '0;
         err_flag <= 1'b0;
         br_taken <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == ST_FETCH && InstrValid)
            ir <= Instruction;
         if (state == ST_MEM && !MemAck) begin
            if (tmo_cnt != TMO_SAT)
               tmo_cnt <= tmo_cnt + 1'b1;
         end else begin
            tmo_cnt <= '0;
         end
         if (state == ST_MEM && !MemAck && tmo_last)
            err_flag <= 1'b1;
         // Zero is sampled at the end of EXEC and the redirect is presented
         // registered in the following cycle, keeping Zero off any output path.
         br_taken <= (state == ST_EXEC) && (cls == CLS_BRANCH) && Zero;
      end
   end

   always_comb begin
      state_nxt   = state;
      Fetch       = 1'b0;
      RegWrEn     = 1'b0;
      MemWrEn     = 1'b0;
      MemRdEn     = 1'b0;
      LoadInst    = 1'b0;
      BranchTaken = br_taken;
      PCTarg      = (cls == CLS_BRANCH) ? ir[TW+1:2] : '0;
      Busy        = (state != ST_IDLE) && (state != ST_HALT);
      Ack         = 1'b0;
      Err         = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Start)
               state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            Fetch = 1'b1;
            if (InstrValid)
               state_nxt = ST_EXEC;
         end
         ST_EXEC: begin
            case (cls)
               CLS_HALT:             state_nxt = ST_HALT;
               CLS_STORE, CLS_LOAD:  state_nxt = ST_MEM;
               CLS_ALU: begin
                  RegWrEn   = 1'b1;
                  state_nxt = ST_FETCH;
               end
               default:              state_nxt = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            MemWrEn  = (cls == CLS_STORE);
            MemRdEn  = (cls == CLS_LOAD);
            LoadInst = (cls == CLS_LOAD);
            if (MemAck) begin
               RegWrEn   = (cls == CLS_LOAD);
               state_nxt = ST_FETCH;
            end else if (tmo_last) begin
               state_nxt = ST_HALT;
            end
         end
         ST_HALT: begin
            Ack = 1'b1;
            Err = err_flag;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef CTRL_SEQ_STATS_EN
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         InstrCount <= 16'h0000;
         CycleCount <= 16'h0000;
      end else begin
         if (state == ST_EXEC && InstrCount != 16'hFFFF)
            InstrCount <= InstrCount + 16'h0001;
         if (Busy && CycleCount != 16'hFFFF)
            CycleCount <= CycleCount + 16'h0001;
      end
   end
`endif

endmodule
`default_nettype wire
